uart_rx: RTL and testbench

UART receiver for 8N1 frames: 1 start bit (low), 8 data bits LSB-first, no parity, 1 stop bit (high). Sits on the serial input pin opposite the team's 8N1 transmitter and shares its bit-timing parameter.
Synchronizes the asynchronous rxd line, validates the start bit at mid-bit, samples each data bit at mid-bit, and checks the stop bit.
Delivers each byte on a one-cycle valid strobe, with framing-error and overrun flags.

---
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the 8N1 receiver: data/strobes out, acknowledge in.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, rx_busy,
        input  rx_ack
    );
    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, rx_busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, one-cycle
// valid/frame_err strobes, pending flag with sticky overrun.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    uart_rx_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_e      state_q;
    logic        sync1_q, sync2_q;
    logic [15:0] clk_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, frame_err_q, overrun_q, rx_busy_q;
    logic        pending_q, ovr_chk_q;
    logic        rxd_s;

    assign rxd_s = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            pending_q   <= 1'b0;
            ovr_chk_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            // The overrun verdict is taken at the end of the strobe cycle, so an
            // ack coinciding with rx_valid retires the old byte; the new one stays pending.
            if (rx_valid_q) begin
                if (ovr_chk_q && !bus.rx_ack) overrun_q <= 1'b1;
                pending_q <= 1'b1;
            end else if (bus.rx_ack) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!rxd_s) begin
                        state_q   <= START;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt_q == HALF) begin
                        clk_cnt_q <= '0;
                        if (rxd_s) begin
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_cnt_q == LAST) begin
                        clk_cnt_q <= '0;
                        shreg_q   <= {rxd_s, shreg_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (clk_cnt_q == LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                        if (rxd_s) begin
                            rx_data_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                            ovr_chk_q  <= pending_q && !bus.rx_ack;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.rx_busy   = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; frames are built from the 8N1 rule
// and results compared against a byte-level pending/overrun model.
module tb_uart_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor, sampled on the falling edge.
    int valid_cnt = 0, fe_cnt = 0, both_cnt = 0, busy_cycles = 0;
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_cnt++;
            got_q.push_back(bus.rx_data);
        end
        if (bus.frame_err) fe_cnt++;
        if (bus.rx_valid && bus.rx_busy) both_cnt++;
        if (bus.rx_busy) busy_cycles++;
    end

    // Reference model state at byte granularity.
    bit         pending_m = 0;
    bit         overrun_m = 0;
    logic [7:0] last_m = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            @(negedge clk);
            if (bus.rx_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 bus.rx_ack = 1'b1;
        @(posedge clk); #1 bus.rx_ack = 1'b0;
        pending_m = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        rxd = 1'b1;
        bus.rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", bus.rx_data, 8'h00);
        chk("rst_valid", bus.rx_valid, 1'b0);
        chk("rst_ferr", bus.frame_err, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);
        chk("rst_busy", bus.rx_busy, 1'b0);
        rst_n = 1'b1;
        pending_m = 0;
        overrun_m = 0;
        last_m = 8'h00;
        got_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        logic [7:0] g;
        if (got_q.size() == 0) begin
            g = 8'hxx;
        end else begin
            g = got_q.pop_front();
        end
        chk(tag, g, exp);
    endtask

    // mode 0: no ack, 1: ack after the strobe, 2: ack during the strobe cycle
    task automatic send_frame(input logic [7:0] b, input int mode);
        bit ok;
        ok = 1;
        if (mode == 2) begin
            fork
                send(b, 1'b1);
                begin
                    wait_valid(ok);
                    if (ok) begin
                        bus.rx_ack = 1'b1;
                        @(posedge clk); #1 bus.rx_ack = 1'b0;
                    end
                end
            join
            chk("strobe_seen", ok, 1'b1);
        end else begin
            send(b, 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
        if (pending_m && mode != 2) overrun_m = 1;
        pending_m = 1;
        last_m = b;
        pop_check("frame_data", b);
        chk("frame_rx_data", bus.rx_data, b);
        chk("frame_ovr", bus.overrun, overrun_m);
        if (mode == 1) ack_pulse();
    endtask

    initial begin
        int vb, fb;
        bit ok0, ok1;
        logic [7:0] rb;
        logic [7:0] fr5a;
        bus.rx_ack = 1'b0;

        do_reset();

        // Single frame A5.
        busy_cycles = 0;
        vb = valid_cnt;
        send_frame(8'hA5, 1);
        chk("a5_one_strobe", valid_cnt - vb, 1);
        chk("a5_no_ferr", fe_cnt, 0);
        chk("a5_busy_lo", busy_cycles >= 9 * CPB, 1'b1);
        chk("a5_busy_hi", busy_cycles <= 10 * CPB, 1'b1);

        // Back-to-back 00 then FF, ack after each strobe.
        vb = valid_cnt;
        ok0 = 0; ok1 = 0;
        fork
            begin
                send(8'h00, 1'b1);
                send(8'hFF, 1'b1);
            end
            begin
                wait_valid(ok0);
                if (ok0) begin
                    @(posedge clk); #1 bus.rx_ack = 1'b1;
                    @(posedge clk); #1 bus.rx_ack = 1'b0;
                    wait_valid(ok1);
                    if (ok1) begin
                        @(posedge clk); #1 bus.rx_ack = 1'b1;
                        @(posedge clk); #1 bus.rx_ack = 1'b0;
                    end
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        pending_m = 0;
        last_m = 8'hFF;
        chk("b2b_seen0", ok0, 1'b1);
        chk("b2b_seen1", ok1, 1'b1);
        chk("b2b_count", valid_cnt - vb, 2);
        pop_check("b2b_data0", 8'h00);
        pop_check("b2b_data1", 8'hFF);
        chk("b2b_ovr", bus.overrun, 1'b0);

        // Stop bit low -> framing error only.
        vb = valid_cnt; fb = fe_cnt;
        send(8'h3C, 1'b0);
        rxd = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("ferr_pulse", fe_cnt - fb, 1);
        chk("ferr_no_valid", valid_cnt - vb, 0);
        chk("ferr_data_kept", bus.rx_data, last_m);
        chk("ferr_busy", bus.rx_busy, 1'b0);

        // Short low glitch is rejected at the start mid-check.
        vb = valid_cnt; fb = fe_cnt;
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_no_valid", valid_cnt - vb, 0);
        chk("glitch_no_ferr", fe_cnt - fb, 0);
        chk("glitch_busy", bus.rx_busy, 1'b0);

        // Overrun without ack.
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        chk("ovr_set", bus.overrun, 1'b1);
        chk("ovr_newest", bus.rx_data, 8'h22);

        // Same with ack in the second strobe cycle.
        do_reset();
        send_frame(8'h11, 0);
        send_frame(8'h22, 2);
        chk("ovr_acked", bus.overrun, 1'b0);
        chk("ovr_acked_data", bus.rx_data, 8'h22);

        // Reset during data bit 4 of 5A.
        vb = valid_cnt; fb = fe_cnt;
        fr5a = 8'h5A;
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rxd = fr5a[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd = fr5a[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        chk("mid_busy", bus.rx_busy, 1'b1);
        do_reset();
        chk("mid_no_valid", valid_cnt - vb, 0);
        chk("mid_no_ferr", fe_cnt - fb, 0);
        send_frame(8'h5A, 1);

        // Randomized bytes and ack policies.
        for (int n = 0; n < 8; n++) begin
            rb = 8'($urandom);
            send_frame(rb, int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end

        chk("busy_valid_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
